// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core pipeline and a word-wide data memory.
// It runs one access per core request, builds byte enables and lane-replicated store
// data, formats and extends load data, and holds the core stalled until the access ends.
// Optional feature macro: LSU_MISALIGN_CHECK_EN. When it is defined, misaligned halfword
// and word accesses are refused without touching memory and flagged on core_misalign_o.
// When it is undefined, the low address bits that a halfword or word cannot use are ignored.
module riscv_lsu #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_req_o,
    output logic        core_err_o,
    output logic        core_misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    size_q;
    logic [1:0]    off_q;

    logic [3:0]    req_be;
    logic [31:0]   req_wd;
    logic          req_misalign;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_data;

    // The core may only advance when no access is pending; in IDLE the request itself stalls.
    assign core_stall_req_o = !rst_i && (((state == IDLE) && core_req_i) || (state == BUSY));

    // Lane control for a new request: low size bits pick byte/half/word, codes 3/6/7 act as word.
    always_comb begin
        req_be       = 4'b1111;
        req_wd       = core_wd_i;
        req_misalign = 1'b0;
        case (core_size_i[1:0])
            2'b00: begin
                req_be = 4'b0001 << core_addr_i[1:0];
                req_wd = {4{core_wd_i[7:0]}};
            end
            2'b01: begin
                req_be = core_addr_i[1] ? 4'b1100 : 4'b0011;
                req_wd = {2{core_wd_i[15:0]}};
`ifdef LSU_MISALIGN_CHECK_EN
                req_misalign = core_addr_i[0];
`endif
            end
            default: begin
                req_be = 4'b1111;
                req_wd = core_wd_i;
`ifdef LSU_MISALIGN_CHECK_EN
                req_misalign = (core_addr_i[1:0] != 2'b00);
`endif
            end
        endcase
        if (!core_we_i) begin
            req_be = 4'b1111;
        end else begin
            req_be = req_be;
        end
    end

    // Load formatting: pick the addressed lane of the returned word, then sign/zero extend.
    always_comb begin
        ld_byte = mem_rd_i[7:0];
        ld_half = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        ld_data = mem_rd_i;
        case (off_q)
            2'd0:    ld_byte = mem_rd_i[7:0];
            2'd1:    ld_byte = mem_rd_i[15:8];
            2'd2:    ld_byte = mem_rd_i[23:16];
            2'd3:    ld_byte = mem_rd_i[31:24];
            default: ld_byte = mem_rd_i[7:0];
        endcase
        case (size_q)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {24'h000000, ld_byte};
            3'd5:    ld_data = {16'h0000, ld_half};
            default: ld_data = mem_rd_i;
        endcase
    end

    // Access sequencer: latches the request, drives memory from the latches, tracks the wait limit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            size_q          <= 3'd0;
            off_q           <= 2'd0;
            core_rd_o       <= 32'd0;
            core_err_o      <= 1'b0;
            core_misalign_o <= 1'b0;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_be_o        <= 4'd0;
            mem_addr_o      <= 32'd0;
            mem_wd_o        <= 32'd0;
        end else begin
            core_err_o      <= 1'b0;
            core_misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req_i) begin
                        mem_we_o   <= core_we_i;
                        mem_be_o   <= req_be;
                        mem_addr_o <= {core_addr_i[31:2], 2'b00};
                        mem_wd_o   <= req_wd;
                        size_q     <= core_size_i;
                        off_q      <= core_addr_i[1:0];
                        wait_cnt   <= '0;
                        if (req_misalign) begin
                            mem_req_o       <= 1'b0;
                            core_misalign_o <= 1'b1;
                            state           <= DONE;
                        end else begin
                            mem_req_o <= 1'b1;
                            state     <= BUSY;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (mem_ready_i) begin
                        if (!mem_we_o) begin
                            core_rd_o <= ld_data;
                        end else begin
                            core_rd_o <= core_rd_o;
                        end
                        mem_req_o <= 1'b0;
                        state     <= DONE;
                    end else if ((MAX_WAIT != 32'd0) && (wait_cnt == CW'(MAX_WAIT))) begin
                        mem_req_o  <= 1'b0;
                        core_err_o <= 1'b1;
                        state      <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    mem_req_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
